fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/fetch_stage_if.sv | 21 ++
 rtl/Mux2x1.sv | 11 +
 rtl/fetch_stage.sv | 203 ++++++++++++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, IF/ID
// update selector, NOP word and PC alignment helpers.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  // How the IF/ID register is updated at the next edge
  typedef enum logic [1:0] {
    IFID_KEEP   = 2'd0,
    IFID_MEM    = 2'd1,
    IFID_BUF    = 2'd2,
    IFID_BUBBLE = 2'd3
  } ifid_op_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam int          ALIGN_W    = 2;
  localparam logic [63:0] PC_STEP    = 64'd4;
  localparam logic [63:0] ALIGN_MASK = {{(64 - ALIGN_W){1'b1}}, {ALIGN_W{1'b0}}};

  // Clear the low alignment bits of a redirect target
  function automatic logic [63:0] align_pc(input logic [63:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory request/response bus between the fetch stage and memory.
interface fetch_stage_if;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemRdy;
  logic [31:0] IMemData;

  modport master (
    output IMemReq,
    output IMemAddr,
    input  IMemRdy,
    input  IMemData
  );

  modport slave (
    input  IMemReq,
    input  IMemAddr,
    output IMemRdy,
    output IMemData
  );
endinterface

// File: rtl/Mux2x1.sv
// Generic two-input multiplexer: y = sel ? d1 : d0.
module Mux2x1 #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, FETCH/HOLD/DRAIN request FSM,
// one-entry skid buffer for stalled responses, and registered IF/ID outputs.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallF,
  input  logic               PCSF,
  input  logic [63:0]        PCTargetD,
  fetch_stage_if.master      imem,
  output logic [31:0]        InstrD,
  output logic [63:0]        PCD,
  output logic [63:0]        PCPlus4D,
  output logic               ValidD
);

  fetch_state_e state_r;
  fetch_state_e state_n_s;
  ifid_op_e     ifid_op_s;

  logic [63:0] pcf_r;
  logic [63:0] pend_r;
  logic [63:0] pend_n_s;
  logic [63:0] buf_pc_r;
  logic [31:0] buf_instr_r;
  logic        buf_load_s;

  logic        pcf_load_s;
  logic        redir_sel_s;
  logic        seq_from_buf_s;
  logic [63:0] seq_base_s;
  logic [63:0] seq_pc_s;
  logic [63:0] tgt_aligned_s;
  logic [63:0] redir_tgt_s;
  logic [63:0] pc_next_s;

  logic [31:0] instr_d_r;
  logic [63:0] pc_d_r;
  logic [63:0] pc4_d_r;
  logic        valid_d_r;

  assign tgt_aligned_s = align_pc(PCTargetD);
  assign seq_base_s    = seq_from_buf_s ? buf_pc_r : pcf_r;
  assign seq_pc_s      = seq_base_s + PC_STEP;

  Mux2x1 #(.WIDTH(64)) u_next_pc_mux (
    .d0  (seq_pc_s),
    .d1  (redir_tgt_s),
    .sel (redir_sel_s),
    .y   (pc_next_s)
  );

  // The request address is the PC register itself, so it cannot move while a request waits
  assign imem.IMemAddr = pcf_r;
  assign imem.IMemReq  = (state_r != ST_HOLD);

  // Next-state, PC update, skid buffer and IF/ID update decisions
  always_comb begin
    state_n_s      = state_r;
    ifid_op_s      = IFID_KEEP;
    pcf_load_s     = 1'b0;
    redir_sel_s    = 1'b0;
    seq_from_buf_s = 1'b0;
    redir_tgt_s    = tgt_aligned_s;
    pend_n_s       = pend_r;
    buf_load_s     = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if (PCSF) begin
          ifid_op_s = IFID_BUBBLE;
          if (imem.IMemRdy) begin
            pcf_load_s  = 1'b1;
            redir_sel_s = 1'b1;
            state_n_s   = ST_FETCH;
          end else begin
            // Request still outstanding: keep the address and wait for it to retire
            pend_n_s  = tgt_aligned_s;
            state_n_s = ST_DRAIN;
          end
        end else if (imem.IMemRdy) begin
          if (StallF) begin
            buf_load_s = 1'b1;
            state_n_s  = ST_HOLD;
          end else begin
            ifid_op_s  = IFID_MEM;
            pcf_load_s = 1'b1;
          end
        end else begin
          if (StallF) begin
            ifid_op_s = IFID_KEEP;
          end else begin
            ifid_op_s = IFID_BUBBLE;
          end
        end
      end
      ST_HOLD: begin
        if (PCSF) begin
          ifid_op_s   = IFID_BUBBLE;
          pcf_load_s  = 1'b1;
          redir_sel_s = 1'b1;
          state_n_s   = ST_FETCH;
        end else if (!StallF) begin
          ifid_op_s      = IFID_BUF;
          pcf_load_s     = 1'b1;
          seq_from_buf_s = 1'b1;
          state_n_s      = ST_FETCH;
        end else begin
          ifid_op_s = IFID_KEEP;
        end
      end
      ST_DRAIN: begin
        ifid_op_s = IFID_BUBBLE;
        if (PCSF) begin
          pend_n_s    = tgt_aligned_s;
          redir_tgt_s = tgt_aligned_s;
        end else begin
          redir_tgt_s = pend_r;
        end
        if (imem.IMemRdy) begin
          pcf_load_s  = 1'b1;
          redir_sel_s = 1'b1;
          state_n_s   = ST_FETCH;
        end else begin
          state_n_s = ST_DRAIN;
        end
      end
      default: begin
        ifid_op_s = IFID_BUBBLE;
        state_n_s = ST_FETCH;
      end
    endcase
  end

  // FSM state, PC, pending redirect target and skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_FETCH;
      pcf_r       <= RESET_PC;
      pend_r      <= 64'h0;
      buf_pc_r    <= 64'h0;
      buf_instr_r <= 32'h0;
    end else begin
      state_r <= state_n_s;
      pend_r  <= pend_n_s;
      if (pcf_load_s) begin
        pcf_r <= pc_next_s;
      end else begin
        pcf_r <= pcf_r;
      end
      if (buf_load_s) begin
        buf_pc_r    <= pcf_r;
        buf_instr_r <= imem.IMemData;
      end else begin
        buf_pc_r    <= buf_pc_r;
        buf_instr_r <= buf_instr_r;
      end
    end
  end

  // IF/ID pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d_r <= NOP_INSTR;
      pc_d_r    <= 64'h0;
      pc4_d_r   <= 64'h0;
      valid_d_r <= 1'b0;
    end else begin
      case (ifid_op_s)
        IFID_MEM: begin
          instr_d_r <= imem.IMemData;
          pc_d_r    <= pcf_r;
          pc4_d_r   <= seq_pc_s;
          valid_d_r <= 1'b1;
        end
        IFID_BUF: begin
          instr_d_r <= buf_instr_r;
          pc_d_r    <= buf_pc_r;
          pc4_d_r   <= seq_pc_s;
          valid_d_r <= 1'b1;
        end
        IFID_BUBBLE: begin
          instr_d_r <= NOP_INSTR;
          valid_d_r <= 1'b0;
        end
        IFID_KEEP: begin
          instr_d_r <= instr_d_r;
        end
        default: begin
          instr_d_r <= instr_d_r;
        end
      endcase
    end
  end

  assign InstrD   = instr_d_r;
  assign PCD      = pc_d_r;
  assign PCPlus4D = pc4_d_r;
  assign ValidD   = valid_d_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage; memory returns {16'hC0DE, addr[15:0]}.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        pcs;
  logic [63:0] tgt;
  logic        rdy;
  logic [31:0] instr_d;
  logic [63:0] pc_d;
  logic [63:0] pc4_d;
  logic        valid_d;

  int vec_cnt;
  int miscompare_cnt;

  fetch_stage_if bus ();

  assign bus.IMemRdy  = rdy;
  assign bus.IMemData = {16'hC0DE, bus.IMemAddr[15:0]};

  fetch_stage #(.RESET_PC(64'h1000)) dut (
    .clk       (clk),
    .rst       (rst),
    .StallF    (stall),
    .PCSF      (pcs),
    .PCTargetD (tgt),
    .imem      (bus),
    .InstrD    (instr_d),
    .PCD       (pc_d),
    .PCPlus4D  (pc4_d),
    .ValidD    (valid_d)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt = vec_cnt + 1;
    if (obs !== exp) begin
      miscompare_cnt = miscompare_cnt + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_cnt = 0;
    miscompare_cnt = 0;
    rst = 1'b1; rdy = 1'b0; stall = 1'b0; pcs = 1'b0; tgt = 64'h0;
    step(); step();
    check_vec("rst_valid", 64'(valid_d), 64'h0);
    check_vec("rst_instr", 64'(instr_d), 64'(NOP));
    check_vec("rst_pcd", pc_d, 64'h0);
    check_vec("rst_pc4", pc4_d, 64'h0);
    check_vec("rst_addr", bus.IMemAddr, 64'h1000);
    check_vec("rst_req", 64'(bus.IMemReq), 64'h1);

    // sequential fetch
    rst = 1'b0; rdy = 1'b1;
    step();
    check_vec("seq_a_instr", 64'(instr_d), 64'hC0DE1000);
    check_vec("seq_a_pcd", pc_d, 64'h1000);
    check_vec("seq_a_pc4", pc4_d, 64'h1004);
    check_vec("seq_a_valid", 64'(valid_d), 64'h1);
    check_vec("seq_b_addr", bus.IMemAddr, 64'h1004);

    // stall with a response in flight -> skid buffer, HOLD
    stall = 1'b1;
    step();
    check_vec("stall_instr", 64'(instr_d), 64'hC0DE1000);
    check_vec("stall_req", 64'(bus.IMemReq), 64'h0);
    step(); step();
    check_vec("stall3_instr", 64'(instr_d), 64'hC0DE1000);
    check_vec("stall3_req", 64'(bus.IMemReq), 64'h0);
    check_vec("stall3_valid", 64'(valid_d), 64'h1);
    stall = 1'b0;
    step();
    check_vec("rel_instr", 64'(instr_d), 64'hC0DE1004);
    check_vec("rel_pcd", pc_d, 64'h1004);
    check_vec("rel_addr", bus.IMemAddr, 64'h1008);
    check_vec("rel_req", 64'(bus.IMemReq), 64'h1);
    step();
    check_vec("seq_c_instr", 64'(instr_d), 64'hC0DE1008);
    check_vec("seq_c_pcd", pc_d, 64'h1008);

    // redirect with response present, misaligned target
    pcs = 1'b1; tgt = 64'h2002;
    step();
    check_vec("flush_valid", 64'(valid_d), 64'h0);
    check_vec("flush_instr", 64'(instr_d), 64'(NOP));
    check_vec("flush_addr", bus.IMemAddr, 64'h2000);
    pcs = 1'b0;
    step();
    check_vec("tgt_instr", 64'(instr_d), 64'hC0DE2000);
    check_vec("tgt_pcd", pc_d, 64'h2000);

    // redirect while request outstanding -> DRAIN
    rdy = 1'b0; pcs = 1'b1; tgt = 64'h3000;
    step();
    check_vec("drain_addr", bus.IMemAddr, 64'h2004);
    check_vec("drain_valid", 64'(valid_d), 64'h0);
    check_vec("drain_req", 64'(bus.IMemReq), 64'h1);
    pcs = 1'b0;
    step();
    check_vec("drain2_addr", bus.IMemAddr, 64'h2004);
    check_vec("drain2_valid", 64'(valid_d), 64'h0);
    rdy = 1'b1;
    step();
    check_vec("drained_addr", bus.IMemAddr, 64'h3000);
    check_vec("drained_valid", 64'(valid_d), 64'h0);
    check_vec("drained_instr", 64'(instr_d), 64'(NOP));
    step();
    check_vec("redir_instr", 64'(instr_d), 64'hC0DE3000);
    check_vec("redir_pcd", pc_d, 64'h3000);

    // flush wins over stall in HOLD
    stall = 1'b1;
    step();
    check_vec("hold_instr", 64'(instr_d), 64'hC0DE3000);
    check_vec("hold_req", 64'(bus.IMemReq), 64'h0);
    pcs = 1'b1; tgt = 64'h5000;
    step();
    check_vec("hflush_valid", 64'(valid_d), 64'h0);
    check_vec("hflush_instr", 64'(instr_d), 64'(NOP));
    check_vec("hflush_addr", bus.IMemAddr, 64'h5000);
    check_vec("hflush_req", 64'(bus.IMemReq), 64'h1);
    pcs = 1'b0; stall = 1'b0;
    step();
    check_vec("hnext_instr", 64'(instr_d), 64'hC0DE5000);
    check_vec("hnext_pcd", pc_d, 64'h5000);

    // reset during DRAIN discards pending target
    rdy = 1'b0; pcs = 1'b1; tgt = 64'h4000;
    step();
    check_vec("prerst_addr", bus.IMemAddr, 64'h5004);
    pcs = 1'b0; rst = 1'b1;
    step();
    check_vec("rstd_addr", bus.IMemAddr, 64'h1000);
    check_vec("rstd_valid", 64'(valid_d), 64'h0);
    check_vec("rstd_pcd", pc_d, 64'h0);
    rst = 1'b0;
    step();
    check_vec("postrst_addr", bus.IMemAddr, 64'h1000);
    check_vec("postrst_req", 64'(bus.IMemReq), 64'h1);
    rdy = 1'b1;
    step();
    check_vec("postrst_instr", 64'(instr_d), 64'hC0DE1000);
    check_vec("postrst_next", bus.IMemAddr, 64'h1004);

    // no response: stall holds, no stall bubbles
    rdy = 1'b0; stall = 1'b1;
    step();
    check_vec("nordy_hold_instr", 64'(instr_d), 64'hC0DE1000);
    check_vec("nordy_hold_valid", 64'(valid_d), 64'h1);
    stall = 1'b0;
    step();
    check_vec("nordy_bub_valid", 64'(valid_d), 64'h0);
    check_vec("nordy_bub_instr", 64'(instr_d), 64'(NOP));

    // PC wraps modulo 2^64
    rdy = 1'b1; pcs = 1'b1; tgt = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    check_vec("wrap_tgt_addr", bus.IMemAddr, 64'hFFFF_FFFF_FFFF_FFFC);
    pcs = 1'b0;
    step();
    check_vec("wrap_instr", 64'(instr_d), 64'hC0DEFFFC);
    check_vec("wrap_pcd", pc_d, 64'hFFFF_FFFF_FFFF_FFFC);
    check_vec("wrap_pc4", pc4_d, 64'h0);
    check_vec("wrap_addr", bus.IMemAddr, 64'h0);

    // redirect in DRAIN overwrites pending target
    rdy = 1'b0; pcs = 1'b1; tgt = 64'h6000;
    step();
    check_vec("ow_addr", bus.IMemAddr, 64'h0);
    tgt = 64'h7000;
    step();
    check_vec("ow2_addr", bus.IMemAddr, 64'h0);
    pcs = 1'b0; rdy = 1'b1;
    step();
    check_vec("ow_done_addr", bus.IMemAddr, 64'h7000);
    check_vec("ow_done_valid", 64'(valid_d), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
